exu_seq_ctrl: RTL
=================

Name: exu_seq_ctrl

Overview:
Multi-cycle sequencer for the core datapath: fetch, execute, memory access and write-back.
- Drives valid/ready handshakes to the instruction fetch port and the load/store port.
- Latches the fetched instruction that feeds the decoder and the combinational EXU.
- Generates register-file and PC write enables; halts on ebreak, illegal opcode or bus timeout.

Parameters:
DATA_WIDTH, 32, instruction/data width.
TIMEOUT, 255, max cycles spent in any handshake state before bus error (1..255).

Ports:
clk  in  1  core clock, rising edge.
rst  in  1  asynchronous, active-high reset.
ifu_req_valid_o  out  1  fetch request valid.
ifu_req_ready_i  in  1  fetch port accepts request.
ifu_rsp_valid_i  in  1  fetched instruction valid.
ifu_rsp_ready_o  out  1  controller accepts fetch response.
inst_i  in  DATA_WIDTH  fetched instruction.
inst_o  out  DATA_WIDTH  latched instruction to IDU/EXU.
lsu_req_valid_o  out  1  load/store request valid.
lsu_req_ready_i  in  1  LSU accepts request.
lsu_wen_o  out  1  1 = store, 0 = load; valid with lsu_req_valid_o.
lsu_rsp_valid_i  in  1  LSU completion (load data / store ack).
lsu_rsp_ready_o  out  1  controller accepts LSU response.
rf_wen_o  out  1  register-file write enable, one-cycle pulse.
pc_wen_o  out  1  PC update enable, one-cycle pulse.
state_o  out  3  current FSM state encoding.
halt_o  out  1  core halted (sticky).
illegal_o  out  1  halt cause: illegal opcode (sticky).
bus_err_o  out  1  halt cause: handshake timeout (sticky).
retire_cnt_o  out  32  retired-instruction counter.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE; inst_o=0; retire_cnt_o=0; wait counter=0.
  - All valid/ready/wen outputs, halt_o, illegal_o and bus_err_o are 0.
- State encoding: IDLE=0, FETCH_REQ=1, FETCH_WAIT=2, EXEC=3, MEM_REQ=4, MEM_WAIT=5, WB=6, HALT=7.
- IDLE: lasts one cycle after reset release, then goes to FETCH_REQ.
- FETCH_REQ:
  - ifu_req_valid_o=1.
  - When ifu_req_ready_i=1, go to FETCH_WAIT.
  - valid stays high and stable until accepted.
- FETCH_WAIT:
  - ifu_rsp_ready_o=1.
  - When ifu_rsp_valid_i=1, latch inst_i into inst_o and go to EXEC.
  - ifu_rsp_valid_i is ignored in every other state.
- EXEC: decode opcode = inst_o[6:0].
  - LOAD (0000011) or STORE (0100011): go to MEM_REQ.
  - inst_o == 0x00100073 (ebreak): go to HALT, halt_o=1.
  - Other SYSTEM (1110011): treated as WB-class.
  - LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, OP-IMM 0010011, OP 0110011: go to WB.
  - Any other opcode: go to HALT, illegal_o=1, halt_o=1; no write enables.
- MEM_REQ:
  - lsu_req_valid_o=1; lsu_wen_o=1 iff STORE.
  - On lsu_req_ready_i=1, go to MEM_WAIT.
- MEM_WAIT:
  - lsu_rsp_ready_o=1.
  - On lsu_rsp_valid_i=1, go to WB.
- WB (one cycle):
  - pc_wen_o=1.
  - rf_wen_o=1 unless opcode is STORE or BRANCH, or rd (inst_o[11:7]) == 0.
  - retire_cnt_o increments, wrapping 0xFFFFFFFF to 0.
  - Next state FETCH_REQ.
- Latency with zero-wait memory (ready/valid already high):
  - ALU instruction: 4 cycles from FETCH_REQ entry to WB inclusive.
  - Load/store: 6 cycles.
- Timeout:
  - Wait counter clears on entry to FETCH_REQ, FETCH_WAIT, MEM_REQ and MEM_WAIT, and increments each cycle the state is not left.
  - When counter == TIMEOUT and the handshake still has not completed, next state is HALT and bus_err_o=1.
  - A handshake completing on the TIMEOUT cycle wins; no error.
- HALT:
  - Absorbing; all valid/ready/wen outputs 0.
  - inst_o and retire_cnt_o hold.
  - Only rst exits HALT.
- rst asserted in any state, including mid-handshake, aborts immediately.
  - Valids drop asynchronously; no completion pulses are generated.
- Outputs are Moore (decoded from registered state), except that transitions sample the inputs.

Test Plan:
- addi x1,x0,5 (0x00500093), zero-wait memory -> states 1,2,3,6; rf_wen_o=1 and pc_wen_o=1 in cycle 4 only; retire_cnt_o becomes 1.
- lw x2,0(x1) (0x0000A103), ifu_req_ready_i delayed 3 cycles, LSU zero-wait -> ifu_req_valid_o held 4 cycles; lsu_req_valid_o=1 with lsu_wen_o=0; rf_wen_o pulse in WB.
- sw x2,4(x1) (0x0020A223) then x0 write addi x0,x0,1 (0x00100013) -> lsu_wen_o=1 for the store; rf_wen_o=0 in WB for both; pc_wen_o=1 for both; retire_cnt_o=2.
- ebreak (0x00100073) after one addi -> halt_o=1, state_o=7, retire_cnt_o=1; no further ifu_req_valid_o for 20 cycles.
- Instruction 0x0000007F, and separately lsu_req_ready_i held 0 with TIMEOUT=8 -> illegal_o=1 for the former; for the latter bus_err_o=1 exactly 9 cycles after MEM_REQ entry, state_o=7.
- rst pulsed during FETCH_WAIT (asynchronous, mid-cycle) -> all outputs 0 immediately; after release, IDLE for 1 cycle then FETCH_REQ; retire_cnt_o=0.

Source files
------------

// File: rtl/exu_seq_ctrl_if.sv
// Fetch and load/store handshake bundle between the sequencer and the memory side.
// The master modport is the sequencer; the slave modport is the fetch/LSU side.
interface exu_seq_ctrl_if #(
   parameter int DATA_WIDTH = 32
);

   logic                  ifu_req_valid_o;
   logic                  ifu_req_ready_i;
   logic                  ifu_rsp_valid_i;
   logic                  ifu_rsp_ready_o;
   logic [DATA_WIDTH-1:0] inst_i;

   logic                  lsu_req_valid_o;
   logic                  lsu_req_ready_i;
   logic                  lsu_wen_o;
   logic                  lsu_rsp_valid_i;
   logic                  lsu_rsp_ready_o;

   modport master (
      output ifu_req_valid_o,
      input  ifu_req_ready_i,
      input  ifu_rsp_valid_i,
      output ifu_rsp_ready_o,
      input  inst_i,
      output lsu_req_valid_o,
      input  lsu_req_ready_i,
      output lsu_wen_o,
      input  lsu_rsp_valid_i,
      output lsu_rsp_ready_o
   );

   modport slave (
      input  ifu_req_valid_o,
      output ifu_req_ready_i,
      output ifu_rsp_valid_i,
      input  ifu_rsp_ready_o,
      output inst_i,
      input  lsu_req_valid_o,
      output lsu_req_ready_i,
      input  lsu_wen_o,
      output lsu_rsp_valid_i,
      input  lsu_rsp_ready_o
   );

endinterface

// File: rtl/exu_seq_ctrl.sv
// Multi-cycle core sequencer: fetch, execute, optional memory access, write-back.
// Halts permanently on ebreak, an unknown opcode or a handshake that never completes.
module exu_seq_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   exu_seq_ctrl_if.master        bus,
   output logic [DATA_WIDTH-1:0] inst_o,
   output logic                  rf_wen_o,
   output logic                  pc_wen_o,
   output logic [2:0]            state_o,
   output logic                  halt_o,
   output logic                  illegal_o,
   output logic                  bus_err_o,
   output logic [31:0]           retire_cnt_o
);

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_FETCH_REQ  = 3'd1,
      ST_FETCH_WAIT = 3'd2,
      ST_EXEC       = 3'd3,
      ST_MEM_REQ    = 3'd4,
      ST_MEM_WAIT   = 3'd5,
      ST_WB         = 3'd6,
      ST_HALT       = 3'd7
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;

   localparam logic [DATA_WIDTH-1:0] EBREAK_INST = DATA_WIDTH'(32'h0010_0073);
   localparam logic [7:0]            TIMEOUT_CNT = 8'(TIMEOUT);

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] inst_q, inst_d;
   logic [7:0]            wait_cnt_q, wait_cnt_d;
   logic [31:0]           retire_q, retire_d;
   logic                  halt_q, halt_d;
   logic                  illegal_q, illegal_d;
   logic                  bus_err_q, bus_err_d;

   logic [6:0] opcode;
   logic [4:0] rd;
   logic       is_mem;
   logic       is_store;
   logic       is_branch;
   logic       is_ebreak;
   logic       is_wb_class;
   logic       timed_out;
   logic       in_wait_state;

   assign opcode        = inst_q[6:0];
   assign rd            = inst_q[11:7];
   assign timed_out     = (wait_cnt_q == TIMEOUT_CNT);
   assign in_wait_state = (state_q == ST_FETCH_REQ) || (state_q == ST_FETCH_WAIT) ||
                          (state_q == ST_MEM_REQ)   || (state_q == ST_MEM_WAIT);

   // Opcode classification of the latched instruction.
   always_comb begin
      is_store    = (opcode == OP_STORE);
      is_branch   = (opcode == OP_BRANCH);
      is_mem      = (opcode == OP_LOAD) || (opcode == OP_STORE);
      is_ebreak   = (inst_q == EBREAK_INST);
      is_wb_class = 1'b0;
      case (opcode)
         OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
         OP_BRANCH, OP_IMM, OP_OP, OP_SYSTEM: is_wb_class = 1'b1;
         default:                             is_wb_class = 1'b0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      inst_d     = inst_q;
      retire_d   = retire_q;
      halt_d     = halt_q;
      illegal_d  = illegal_q;
      bus_err_d  = bus_err_q;
      wait_cnt_d = '0;

      case (state_q)
         ST_IDLE: state_d = ST_FETCH_REQ;

         ST_FETCH_REQ: begin
            if (bus.ifu_req_ready_i) begin
               state_d = ST_FETCH_WAIT;
            end else if (timed_out) begin
               state_d   = ST_HALT;
               halt_d    = 1'b1;
               bus_err_d = 1'b1;
            end
         end

         ST_FETCH_WAIT: begin
            if (bus.ifu_rsp_valid_i) begin
               inst_d  = bus.inst_i;
               state_d = ST_EXEC;
            end else if (timed_out) begin
               state_d   = ST_HALT;
               halt_d    = 1'b1;
               bus_err_d = 1'b1;
            end
         end

         // ebreak is itself a SYSTEM opcode, so it must be tested before the WB class.
         ST_EXEC: begin
            if (is_mem) begin
               state_d = ST_MEM_REQ;
            end else if (is_ebreak) begin
               state_d = ST_HALT;
               halt_d  = 1'b1;
            end else if (is_wb_class) begin
               state_d = ST_WB;
            end else begin
               state_d   = ST_HALT;
               halt_d    = 1'b1;
               illegal_d = 1'b1;
            end
         end

         ST_MEM_REQ: begin
            if (bus.lsu_req_ready_i) begin
               state_d = ST_MEM_WAIT;
            end else if (timed_out) begin
               state_d   = ST_HALT;
               halt_d    = 1'b1;
               bus_err_d = 1'b1;
            end
         end

         ST_MEM_WAIT: begin
            if (bus.lsu_rsp_valid_i) begin
               state_d = ST_WB;
            end else if (timed_out) begin
               state_d   = ST_HALT;
               halt_d    = 1'b1;
               bus_err_d = 1'b1;
            end
         end

         ST_WB: begin
            retire_d = retire_q + 32'd1;
            state_d  = ST_FETCH_REQ;
         end

         ST_HALT: state_d = ST_HALT;

         default: state_d = ST_HALT;
      endcase

      // Counter restarts on every state entry, so it only measures the current wait.
      if (in_wait_state && (state_d == state_q)) begin
         wait_cnt_d = wait_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         inst_q     <= '0;
         wait_cnt_q <= '0;
         retire_q   <= '0;
         halt_q     <= 1'b0;
         illegal_q  <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         inst_q     <= inst_d;
         wait_cnt_q <= wait_cnt_d;
         retire_q   <= retire_d;
         halt_q     <= halt_d;
         illegal_q  <= illegal_d;
         bus_err_q  <= bus_err_d;
      end
   end

   logic ifu_req_valid;
   logic ifu_rsp_ready;
   logic lsu_req_valid;
   logic lsu_wen;
   logic lsu_rsp_ready;
   logic rf_wen;
   logic pc_wen;

   // Moore outputs: decoded purely from the registered state so reset clears them at once.
   always_comb begin
      ifu_req_valid = 1'b0;
      ifu_rsp_ready = 1'b0;
      lsu_req_valid = 1'b0;
      lsu_wen       = 1'b0;
      lsu_rsp_ready = 1'b0;
      rf_wen        = 1'b0;
      pc_wen        = 1'b0;
      case (state_q)
         ST_FETCH_REQ:  ifu_req_valid = 1'b1;
         ST_FETCH_WAIT: ifu_rsp_ready = 1'b1;
         ST_MEM_REQ: begin
            lsu_req_valid = 1'b1;
            lsu_wen       = is_store;
         end
         ST_MEM_WAIT:   lsu_rsp_ready = 1'b1;
         ST_WB: begin
            pc_wen = 1'b1;
            rf_wen = !(is_store || is_branch) && (rd != 5'd0);
         end
         default: ;
      endcase
   end

   assign bus.ifu_req_valid_o = ifu_req_valid;
   assign bus.ifu_rsp_ready_o = ifu_rsp_ready;
   assign bus.lsu_req_valid_o = lsu_req_valid;
   assign bus.lsu_wen_o       = lsu_wen;
   assign bus.lsu_rsp_ready_o = lsu_rsp_ready;

   assign inst_o       = inst_q;
   assign rf_wen_o     = rf_wen;
   assign pc_wen_o     = pc_wen;
   assign state_o      = state_q;
   assign halt_o       = halt_q;
   assign illegal_o    = illegal_q;
   assign bus_err_o    = bus_err_q;
   assign retire_cnt_o = retire_q;

endmodule
